// File: rtl/pong_pkg.sv
// pong_pkg
// Shared types and constants for the Pong datapath: the game-flow state
// encoding, score width, winner codes and the screen resolution used by the
// ball tracker and renderer.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        OVER   = 3'd4
    } game_state_t;

    localparam int SCORE_W = 4;

    localparam int X_RESOLUTION = 640;
    localparam int Y_RESOLUTION = 480;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/button_sync.sv
// button_sync
// Brings an active-low pushbutton into the clk domain through two flops and
// emits a one-cycle pulse on each press (high-to-low transition).
// Ports:
//   clk      in  clock
//   reset    in  asynchronous, active-low
//   button_n in  raw active-low button, asynchronous to clk
//   press    out one-cycle pulse, two edges after the button is first sampled low
module button_sync (
    input  logic clk,
    input  logic reset,
    input  logic button_n,
    output logic press
);

    logic sync1;
    logic sync2;
    logic sync2_q;

    // All three flops idle high, matching a released button, so leaving
    // reset never fakes a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1   <= button_n;
            sync2   <= sync1;
            sync2_q <= sync2;
        end
    end

    // Falling edge of the synchronised level.
    assign press = sync2_q & ~sync2;

endmodule

// File: rtl/score_keeper.sv
// score_keeper
// Game-flow controller and scoreboard sitting after the ball tracker. Counts
// points from the tracker's sticky flags, runs the serve delay, pause and
// game-over sequencing, and drives the tracker's motion enable and re-centre
// reset.
// Ports:
//   clk           in  master clock
//   reset         in  asynchronous, active-low
//   start_n       in  start/pause button, active-low, asynchronous
//   player1_point in  sticky level: player 1 scored
//   player2_point in  sticky level: player 2 scored
//   game_on       out ball motion enable
//   ball_rst_n    out one-cycle active-low re-centre pulse on each serve
//   score1        out player 1 score
//   score2        out player 2 score
//   winner        out 00 none, 01 player 1, 10 player 2
//   state         out current game_state_t
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_DELAY = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_n,
    input  logic               player1_point,
    input  logic               player2_point,
    output logic               game_on,
    output logic               ball_rst_n,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    game_state_t        state_q;
    game_state_t        state_next;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_next;
    logic [SCORE_W-1:0] score1_next;
    logic [SCORE_W-1:0] score2_next;
    logic [SCORE_W-1:0] inc1;
    logic [SCORE_W-1:0] inc2;
    logic [1:0]         winner_next;
    logic               game_on_next;
    logic               ball_rst_n_next;
    logic               serve_entry;

    logic start_evt;
    logic p1_q;
    logic p2_q;
    logic p1_evt;
    logic p2_evt;

    button_sync u_start_sync (
        .clk      (clk),
        .reset    (reset),
        .button_n (start_n),
        .press    (start_evt)
    );

    // The point flags stay high until the tracker is re-centred, so only the
    // rising edge counts as a point.
    assign p1_evt = player1_point & ~p1_q;
    assign p2_evt = player2_point & ~p2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            score1     <= '0;
            score2     <= '0;
            winner     <= WIN_NONE;
            game_on    <= 1'b0;
            ball_rst_n <= 1'b0;
            p1_q       <= 1'b0;
            p2_q       <= 1'b0;
        end else begin
            state_q    <= state_next;
            count_q    <= count_next;
            score1     <= score1_next;
            score2     <= score2_next;
            winner     <= winner_next;
            game_on    <= game_on_next;
            ball_rst_n <= ball_rst_n_next;
            p1_q       <= player1_point;
            p2_q       <= player2_point;
        end
    end

    // Next-state and next-output logic. game_on and ball_rst_n are derived
    // from the next state so they change on the same edge as the state.
    always_comb begin
        state_next  = state_q;
        count_next  = count_q;
        score1_next = score1;
        score2_next = score2;
        winner_next = winner;
        inc1        = score1 + SCORE_W'(1);
        inc2        = score2 + SCORE_W'(1);

        case (state_q)
            IDLE: begin
                score1_next = '0;
                score2_next = '0;
                winner_next = WIN_NONE;
                if (start_evt) begin
                    state_next = SERVE;
                end
            end

            SERVE: begin
                if (count_q == '0) begin
                    state_next = PLAY;
                end else begin
                    count_next = count_q - CNT_W'(1);
                end
            end

            PLAY: begin
                // A simultaneous point for both players is replayed unscored.
                if (p1_evt && p2_evt) begin
                    state_next = SERVE;
                end else if (p1_evt) begin
                    score1_next = inc1;
                    if (inc1 == WIN_VAL) begin
                        state_next  = OVER;
                        winner_next = WIN_P1;
                    end else begin
                        state_next = SERVE;
                    end
                end else if (p2_evt) begin
                    score2_next = inc2;
                    if (inc2 == WIN_VAL) begin
                        state_next  = OVER;
                        winner_next = WIN_P2;
                    end else begin
                        state_next = SERVE;
                    end
                end else if (start_evt) begin
                    state_next = PAUSED;
                end
            end

            PAUSED: begin
                if (start_evt) begin
                    state_next = PLAY;
                end
            end

            OVER: begin
                if (start_evt) begin
                    score1_next = '0;
                    score2_next = '0;
                    winner_next = WIN_NONE;
                    state_next  = SERVE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Every way into SERVE reloads the delay and re-centres the ball once.
        serve_entry = (state_next == SERVE) && (state_q != SERVE);
        if (serve_entry) begin
            count_next = SERVE_LOAD;
        end

        game_on_next    = (state_next == PLAY);
        ball_rst_n_next = ~serve_entry;
    end

    assign state = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
// Directed bench for score_keeper with WIN_SCORE=3, SERVE_DELAY=4. The
// stimulus process drives inputs and queues the outputs it expects at a given
// sample index; an independent monitor samples the outputs on every falling
// clock edge (and once on request right after an asynchronous reset) and
// checks them against the queue.
module tb_score_keeper;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SERVE  = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_PAUSED = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    typedef struct {
        int         tag;
        string      name;
        logic [2:0] state;
        logic       game_on;
        logic       ball_rst_n;
        logic [3:0] score1;
        logic [3:0] score2;
        logic [1:0] winner;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start_n;
    logic       player1_point;
    logic       player2_point;
    logic       game_on;
    logic       ball_rst_n;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;
    logic [2:0] state;

    exp_t exp_q[$];
    int   nsamp      = 0;
    int   vectors    = 0;
    int   miscompares = 0;
    event reset_probe;

    score_keeper #(
        .WIN_SCORE   (3),
        .SERVE_DELAY (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_n       (start_n),
        .player1_point (player1_point),
        .player2_point (player2_point),
        .game_on       (game_on),
        .ball_rst_n    (ball_rst_n),
        .score1        (score1),
        .score2        (score2),
        .winner        (winner),
        .state         (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: each sample point bumps the index and checks any expectation
    // queued for it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or reset_probe);
            nsamp++;
            while (exp_q.size() > 0 && exp_q[0].tag <= nsamp) begin
                e = exp_q.pop_front();
                vectors++;
                if (e.tag != nsamp ||
                    state !== e.state || game_on !== e.game_on ||
                    ball_rst_n !== e.ball_rst_n || score1 !== e.score1 ||
                    score2 !== e.score2 || winner !== e.winner) begin
                    miscompares++;
                    $display("[TB] FAIL %s @sample %0d (due %0d): got state=%0d game_on=%b ball_rst_n=%b score1=%0d score2=%0d winner=%b, expected state=%0d game_on=%b ball_rst_n=%b score1=%0d score2=%0d winner=%b",
                             e.name, nsamp, e.tag, state, game_on, ball_rst_n,
                             score1, score2, winner, e.state, e.game_on,
                             e.ball_rst_n, e.score1, e.score2, e.winner);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_sample(input int n);
        while (nsamp < n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Drive inputs just after sample index 'at'; they are taken at the next
    // rising edge and their effect is first visible at sample at+1.
    task automatic applyStimulus(input int at, input logic sn, input logic p1,
                                 input logic p2);
        wait_sample(at);
        start_n       = sn;
        player1_point = p1;
        player2_point = p2;
    endtask

    task automatic checkOutput(input int tag, input string name,
                               input logic [2:0] st, input logic go,
                               input logic brn, input logic [3:0] s1,
                               input logic [3:0] s2, input logic [1:0] w);
        exp_t e;
        e.tag        = tag;
        e.name       = name;
        e.state      = st;
        e.game_on    = go;
        e.ball_rst_n = brn;
        e.score1     = s1;
        e.score2     = s2;
        e.winner     = w;
        exp_q.push_back(e);
    endtask

    initial begin
        reset         = 1'b0;
        start_n       = 1'b1;
        player1_point = 1'b0;
        player2_point = 1'b0;
        checkOutput(1, "reset_values", S_IDLE, 0, 0, 0, 0, 2'b00);

        // Release reset and press start for three cycles.
        applyStimulus(1, 0, 0, 0);
        reset = 1'b1;
        checkOutput(2, "brn_release",   S_IDLE,  0, 1, 0, 0, 2'b00);
        checkOutput(3, "sync_delay",    S_IDLE,  0, 1, 0, 0, 2'b00);
        checkOutput(4, "serve_entry",   S_SERVE, 0, 0, 0, 0, 2'b00);
        checkOutput(5, "serve_brn_hi",  S_SERVE, 0, 1, 0, 0, 2'b00);
        checkOutput(7, "serve_last",    S_SERVE, 0, 1, 0, 0, 2'b00);
        checkOutput(8, "play_entry",    S_PLAY,  1, 1, 0, 0, 2'b00);
        applyStimulus(4, 1, 0, 0);

        // Sticky player 1 point held for ten cycles scores once.
        applyStimulus(8, 1, 1, 0);
        checkOutput(9,  "p1_score",       S_SERVE, 0, 0, 1, 0, 2'b00);
        checkOutput(10, "p1_brn_hi",      S_SERVE, 0, 1, 1, 0, 2'b00);
        checkOutput(12, "p1_serve_last",  S_SERVE, 0, 1, 1, 0, 2'b00);
        checkOutput(13, "p1_play",        S_PLAY,  1, 1, 1, 0, 2'b00);
        checkOutput(17, "p1_sticky_once", S_PLAY,  1, 1, 1, 0, 2'b00);
        applyStimulus(18, 1, 0, 0);

        // Simultaneous points: replay with no score change.
        applyStimulus(19, 1, 1, 1);
        checkOutput(20, "both_replay", S_SERVE, 0, 0, 1, 0, 2'b00);
        checkOutput(24, "both_play",   S_PLAY,  1, 1, 1, 0, 2'b00);
        applyStimulus(20, 1, 0, 0);

        // Three player 2 points reach WIN_SCORE.
        applyStimulus(24, 1, 0, 1);
        checkOutput(25, "p2_first",  S_SERVE, 0, 0, 1, 1, 2'b00);
        checkOutput(29, "p2_play1",  S_PLAY,  1, 1, 1, 1, 2'b00);
        applyStimulus(25, 1, 0, 0);
        applyStimulus(29, 1, 0, 1);
        checkOutput(30, "p2_second", S_SERVE, 0, 0, 1, 2, 2'b00);
        checkOutput(34, "p2_play2",  S_PLAY,  1, 1, 1, 2, 2'b00);
        applyStimulus(30, 1, 0, 0);
        applyStimulus(34, 1, 0, 1);
        checkOutput(35, "p2_win",    S_OVER,  0, 1, 1, 3, 2'b10);
        checkOutput(36, "over_hold", S_OVER,  0, 1, 1, 3, 2'b10);
        applyStimulus(35, 1, 0, 0);

        // Start after game over clears everything and serves again.
        applyStimulus(36, 0, 0, 0);
        checkOutput(38, "over_wait",    S_OVER,  0, 1, 1, 3, 2'b10);
        checkOutput(39, "over_restart", S_SERVE, 0, 0, 0, 0, 2'b00);
        checkOutput(43, "restart_play", S_PLAY,  1, 1, 0, 0, 2'b00);
        applyStimulus(37, 1, 0, 0);

        // Pause, ignore a point, resume without a serve delay.
        applyStimulus(43, 0, 0, 0);
        checkOutput(45, "pause_wait", S_PLAY,   1, 1, 0, 0, 2'b00);
        checkOutput(46, "paused",     S_PAUSED, 0, 1, 0, 0, 2'b00);
        applyStimulus(44, 1, 0, 0);
        applyStimulus(47, 1, 1, 0);
        checkOutput(48, "pause_ignore", S_PAUSED, 0, 1, 0, 0, 2'b00);
        applyStimulus(48, 1, 0, 0);
        applyStimulus(49, 0, 0, 0);
        checkOutput(51, "resume_wait", S_PAUSED, 0, 1, 0, 0, 2'b00);
        checkOutput(52, "resume_play", S_PLAY,   1, 1, 0, 0, 2'b00);
        applyStimulus(50, 1, 0, 0);

        // Score once more, then reset asynchronously with the counter at 2.
        applyStimulus(52, 1, 1, 0);
        checkOutput(53, "serve_mid",  S_SERVE, 0, 0, 1, 0, 2'b00);
        checkOutput(54, "serve_cnt2", S_SERVE, 0, 1, 1, 0, 2'b00);
        applyStimulus(53, 1, 0, 0);
        wait_sample(54);
        reset = 1'b0;
        checkOutput(55, "async_reset", S_IDLE, 0, 0, 0, 0, 2'b00);
        #2;
        vectors++;
        if (state !== S_IDLE) begin
            miscompares++;
            $display("[TB] FAIL async_state: got state=%0d, expected %0d before next edge", state, S_IDLE);
        end
        vectors++;
        if (score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL async_scores: got score1=%0d score2=%0d winner=%b, expected 0 0 00", score1, score2, winner);
        end
        vectors++;
        if (game_on !== 1'b0 || ball_rst_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_ctrl: got game_on=%b ball_rst_n=%b, expected 0 0", game_on, ball_rst_n);
        end
        ->reset_probe;
        checkOutput(56, "reset_held", S_IDLE, 0, 0, 0, 0, 2'b00);
        wait_sample(56);
        reset = 1'b1;
        checkOutput(57, "post_reset", S_IDLE, 0, 1, 0, 0, 2'b00);
        wait_sample(59);

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: never sampled, expected at sample %0d, reached %0d",
                     e.name, e.tag, nsamp);
        end

        if (vectors < 12) begin
            miscompares++;
            $display("[TB] FAIL too few vectors compared: %0d", vectors);
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
